// File: rtl/proj_sequencer.sv
// Issue-side sequencer for the 8-wide projection engine: walks column blocks and pixels,
// requests each block from the column buffer and paces one enable per engine pass.
module proj_sequencer #(
   parameter int NUM_PIXELS  = 161,
   parameter int NUM_WEIGHTS = 400,
   parameter int COLS_SIZE   = 8,
   parameter int PASS_CYCLES = 21
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        blk_ack,
   output logic        blk_req,
   output logic [8:0]  blk_idx,
   output logic        clear,
   output logic        enable,
   output logic [15:0] pixel_iter,
   output logic [8:0]  weight_iter,
   output logic        busy,
   output logic        done
);

   localparam int WCNT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_BLK_REQ,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         p_q, p_d;
   logic [8:0]          wb_q, wb_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                abort_q, abort_d;
   logic                abort_now;

   logic                blk_req_q, blk_req_d;
   logic [8:0]          blk_idx_q, blk_idx_d;
   logic                clear_q, clear_d;
   logic                enable_q, enable_d;
   logic [15:0]         pixel_iter_q, pixel_iter_d;
   logic [8:0]          weight_iter_q, weight_iter_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // NOTE: every variable gets a default at the top of the block so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      wb_d      = wb_q;
      wcnt_d    = wcnt_q;
      abort_now = abort_q | abort;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               p_d     = '0;
               wb_d    = '0;
            end
         end
         S_CLEAR: begin
            state_d = abort_now ? S_IDLE : S_BLK_REQ;
         end
         S_BLK_REQ: begin
            if (abort_now)    state_d = S_IDLE;
            else if (blk_ack) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_W'(PASS_CYCLES - 1);
         end
         S_WAIT: begin
            // An abort seen during a pass only takes effect once that pass has drained.
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end else if (abort_now) begin
               state_d = S_IDLE;
            end else if (32'(p_q) < NUM_PIXELS - 1) begin
               p_d     = p_q + 16'd1;
               state_d = S_ISSUE;
            end else if (32'(wb_q) + COLS_SIZE < NUM_WEIGHTS) begin
               wb_d    = wb_q + 9'(COLS_SIZE);
               p_d     = '0;
               state_d = S_BLK_REQ;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The latch only holds while the sequencer stays busy; IDLE always clears it.
      abort_d = (state_q != S_IDLE) && (state_d != S_IDLE) && abort_now;

      // Outputs are decoded from the next state so they appear registered with the state.
      blk_req_d     = (state_d == S_BLK_REQ);
      blk_idx_d     = (state_d == S_BLK_REQ) ? wb_d : 9'd0;
      clear_d       = (state_d == S_CLEAR);
      enable_d      = (state_d == S_ISSUE);
      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      pixel_iter_d  = pixel_iter_q;
      weight_iter_d = weight_iter_q;
      if (state_d == S_ISSUE) begin
         pixel_iter_d  = p_d;
         weight_iter_d = wb_d;
      end else if (state_d == S_IDLE) begin
         pixel_iter_d  = '0;
         weight_iter_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         p_q           <= '0;
         wb_q          <= '0;
         wcnt_q        <= '0;
         abort_q       <= 1'b0;
         blk_req_q     <= 1'b0;
         blk_idx_q     <= '0;
         clear_q       <= 1'b0;
         enable_q      <= 1'b0;
         pixel_iter_q  <= '0;
         weight_iter_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_q           <= p_d;
         wb_q          <= wb_d;
         wcnt_q        <= wcnt_d;
         abort_q       <= abort_d;
         blk_req_q     <= blk_req_d;
         blk_idx_q     <= blk_idx_d;
         clear_q       <= clear_d;
         enable_q      <= enable_d;
         pixel_iter_q  <= pixel_iter_d;
         weight_iter_q <= weight_iter_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign blk_req     = blk_req_q;
   assign blk_idx     = blk_idx_q;
   assign clear       = clear_q;
   assign enable      = enable_q;
   assign pixel_iter  = pixel_iter_q;
   assign weight_iter = weight_iter_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_proj_sequencer.sv
// Bench for proj_sequencer: a schedule model expands each run (blocks, passes, ack delays,
// abort point) into expected per-cycle outputs, then compares the DUT cycle by cycle.
module tb_proj_sequencer;

   localparam int NP   = 3;
   localparam int NW   = 16;
   localparam int CS   = 8;
   localparam int PC   = 21;
   localparam int NBLK = NW / CS;
   localparam int MAXC = 512;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort, blk_ack;
   logic        blk_req, clear, enable, busy, done;
   logic [8:0]  blk_idx, weight_iter;
   logic [15:0] pixel_iter;

   proj_sequencer #(
      .NUM_PIXELS (NP),
      .NUM_WEIGHTS(NW),
      .COLS_SIZE  (CS),
      .PASS_CYCLES(PC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .blk_ack    (blk_ack),
      .blk_req    (blk_req),
      .blk_idx    (blk_idx),
      .clear      (clear),
      .enable     (enable),
      .pixel_iter (pixel_iter),
      .weight_iter(weight_iter),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Expected outputs per cycle index c (cycle c ends at edge E0+c; start is sampled at E0).
   bit e_clr [MAXC], e_en [MAXC], e_req [MAXC], e_busy [MAXC], e_done [MAXC];
   bit m_idx [MAXC], m_pw [MAXC], d_ack [MAXC];
   int e_idx [MAXC], e_pix [MAXC], e_wi [MAXC];
   int dly [NBLK];
   int en_cycles[$];
   int done_cycle;
   int tp_en [6];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // Lay out the run as a schedule: CLEAR, then per block a request window of dly+1 cycles
   // followed by NP passes of PC+1 cycles each, then DONE; an abort truncates it.
   task automatic build(input int abort_at, output int end_c);
      int  t;
      bit  stop;
      for (int c = 0; c < MAXC; c++) begin
         e_clr[c] = 0; e_en[c] = 0; e_req[c] = 0; e_busy[c] = 0; e_done[c] = 0;
         m_idx[c] = 0; m_pw[c] = 0; d_ack[c] = 0;
         e_idx[c] = 0; e_pix[c] = 0; e_wi[c] = 0;
      end
      stop     = 0;
      end_c    = 1;
      e_clr[1] = 1;
      if (abort_at == 1) stop = 1;
      t = 2;
      for (int b = 0; b < NBLK && !stop; b++) begin
         for (int j = 0; j <= dly[b]; j++) begin
            e_req[t+j] = 1; e_idx[t+j] = b * CS; m_idx[t+j] = 1;
            if (abort_at == t + j) begin
               stop  = 1;
               end_c = t + j;
               break;
            end
         end
         if (!stop) begin
            d_ack[t+dly[b]] = 1;
            t += dly[b] + 1;
            for (int p = 0; p < NP && !stop; p++) begin
               e_en[t] = 1;
               for (int c = t; c <= t + PC; c++) begin
                  e_pix[c] = p; e_wi[c] = b * CS; m_pw[c] = 1;
               end
               if (abort_at >= t && abort_at <= t + PC) begin
                  stop  = 1;
                  end_c = t + PC;
               end
               t += PC + 1;
            end
         end
      end
      if (!stop) begin
         e_done[t] = 1;
         end_c     = t;
      end
      for (int c = 1; c <= end_c; c++) e_busy[c] = 1;
      m_pw[0] = 1;
      for (int c = end_c + 1; c < MAXC; c++) m_pw[c] = 1;
   endtask

   function automatic logic [63:0] obs_vec(input int c);
      return {25'd0, clear, enable, blk_req, busy, done,
              (m_idx[c] ? blk_idx : 9'd0),
              (m_pw[c] ? pixel_iter : 16'd0),
              (m_pw[c] ? weight_iter : 9'd0)};
   endfunction

   function automatic logic [63:0] exp_vec(input int c);
      return {25'd0, e_clr[c], e_en[c], e_req[c], e_busy[c], e_done[c],
              9'(e_idx[c]), 16'(e_pix[c]), 9'(e_wi[c])};
   endfunction

   task automatic run_case(input int id, input int abort_at, input bit ack_noise,
                           input bit start_noise);
      int end_c;
      build(abort_at, end_c);
      en_cycles.delete();
      done_cycle = -1;
      for (int c = 0; c <= end_c + 3; c++) begin
         @(negedge clk);
         check($sformatf("run%0d_cyc%0d", id, c), obs_vec(c), exp_vec(c));
         if (enable) en_cycles.push_back(c);
         if (done && done_cycle < 0) done_cycle = c;
         start   = (c == 0) || (start_noise && c >= 1 && c <= end_c && $urandom_range(0, 3) == 0);
         abort   = (c == abort_at);
         blk_ack = d_ack[c] || (ack_noise && c <= end_c && !e_req[c] && $urandom_range(0, 1) == 1);
      end
      start = 0; abort = 0; blk_ack = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tp_en = '{3, 25, 47, 70, 92, 114};
      rst_n = 1'b0; start = 0; abort = 0; blk_ack = 0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {25'd0, clear, enable, blk_req, busy, done, blk_idx, pixel_iter,
                              weight_iter}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-stall run against the known event times.
      dly = '{0, 0};
      run_case(1, -1, 0, 0);
      check("tp1_enable_count", 64'(en_cycles.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         check($sformatf("tp1_enable%0d", i),
               64'(i < en_cycles.size() ? en_cycles[i] : -1), 64'(tp_en[i]));
      check("tp1_done_cycle", 64'(done_cycle), 64'd136);

      // Five-cycle ack delay per block.
      dly = '{5, 5};
      run_case(2, -1, 0, 0);
      check("tp2_done_cycle", 64'(done_cycle), 64'd146);

      // Start pulses while busy plus ack noise outside request windows.
      dly = '{0, 0};
      run_case(3, -1, 1, 1);
      check("tp3_done_cycle", 64'(done_cycle), 64'd136);

      // Abort during the second pass's WAIT.
      run_case(4, int'($urandom_range(26, 46)), 0, 0);
      check("tp4_no_done", 64'(done_cycle), 64'hFFFF_FFFF_FFFF_FFFF);
      check("tp4_enable_count", 64'(en_cycles.size()), 64'd2);

      // Abort while the block request is still unacknowledged.
      dly = '{12, 0};
      run_case(5, int'($urandom_range(2, 13)), 0, 0);
      check("tp5_no_enable", 64'(en_cycles.size()), 64'd0);

      // Start and abort together in IDLE: start wins.
      dly = '{1, 2};
      run_case(6, 0, 0, 0);
      check("tp6_done_seen", 64'(done_cycle > 0), 64'd1);

      for (int r = 0; r < 8; r++) begin
         for (int b = 0; b < NBLK; b++) dly[b] = int'($urandom_range(0, 6));
         run_case(10 + r, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 170)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a WAIT, then a full run from CLEAR.
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (8) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      #3 rst_n = 1'b0;
      #1 check("async_reset_outputs", {25'd0, clear, enable, blk_req, busy, done, blk_idx,
                                       pixel_iter, weight_iter}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dly = '{0, 3};
      run_case(30, -1, 0, 0);
      check("tp30_done_cycle", 64'(done_cycle), 64'd139);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/proj_sequencer.md
Name: proj_sequencer

Overview:
- Issue-side controller for the 8-wide projection engine. Walks every weight block and every pixel and drives the engine's clear/enable/pixel_iter/weight_iter interface.
- Holds indices stable for each full pass and paces passes to the engine's fixed pass length.
- Requests each new block of COLS_SIZE eigenvector columns from the upstream column buffer through a req/ack handshake.
- Sits between the top-level recognition FSM (start/done) and the projection engine.

Parameters:
- NUM_PIXELS, 161, pixels per face vector; pixel_iter runs 0..NUM_PIXELS-1.
- NUM_WEIGHTS, 400, projection weights; must be a multiple of COLS_SIZE.
- COLS_SIZE, 8, weights computed per pass (engine lane count).
- PASS_CYCLES, 21, cycles after the enable cycle before the engine accepts a new enable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin projection; sampled only in IDLE
- abort  in  1  stop after the in-flight pass drains
- blk_ack  in  1  column block blk_idx now present on the engine's p_in
- blk_req  out  1  request column block blk_idx
- blk_idx  out  9  first weight index of the requested block
- clear  out  1  one-cycle engine accumulator clear
- enable  out  1  one-cycle pass launch
- pixel_iter  out  16  pixel index for the current pass
- weight_iter  out  9  first weight index of the current block
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset and register rules
  - All outputs are registered.
  - Reset values: every output is 0; state is IDLE; counters are 0.
  - Reset asserted mid-operation forces this immediately. Engine state is not this block's concern; a new start always begins with CLEAR.
- States
  - IDLE
    - busy=0.
    - start=1: go to CLEAR with p=0, wb=0.
  - CLEAR
    - clear=1 and busy=1 for exactly one cycle; then go to BLK_REQ.
  - BLK_REQ
    - blk_req=1 and blk_idx=wb, held until blk_ack is sampled high.
    - Then drop blk_req and go to ISSUE.
    - blk_ack outside BLK_REQ is ignored.
  - ISSUE
    - enable=1 for one cycle; pixel_iter=p, weight_iter=wb.
    - Then go to WAIT with wcnt=PASS_CYCLES-1.
  - WAIT
    - enable=0; pixel_iter and weight_iter are held unchanged.
    - Decrement wcnt each cycle; lasts exactly PASS_CYCLES cycles.
    - At wcnt==0:
      - If abort is latched: go to IDLE.
      - Else if p<NUM_PIXELS-1: p++, go to ISSUE.
      - Else if wb+COLS_SIZE<NUM_WEIGHTS: wb+=COLS_SIZE, p=0, go to BLK_REQ.
      - Else go to DONE.
  - DONE
    - done=1 for one cycle; go to IDLE.
    - pixel_iter and weight_iter return to 0 in IDLE.
- Abort
  - abort is latched in any non-IDLE state.
  - In CLEAR or BLK_REQ it takes effect at the next edge: go to IDLE, drop blk_req, no done.
  - In ISSUE or WAIT it waits for the current pass to finish; no further enable is issued.
  - The latch clears in IDLE.
- start while busy is ignored; start and abort together in IDLE means start wins.
- Pacing: enable never asserts twice within PASS_CYCLES+1 cycles. Zero-stall pass period is PASS_CYCLES+1.
- Index widths: p wraps only by explicit reset to 0, never arithmetic overflow. wb is compared before increment, so it never exceeds NUM_WEIGHTS-COLS_SIZE.
- Zero-stall run length: 1 + (NUM_WEIGHTS/COLS_SIZE)·(1+NUM_PIXELS·(PASS_CYCLES+1)) cycles from CLEAR to DONE entry.

Test Plan:
- NUM_PIXELS=3, NUM_WEIGHTS=16, blk_ack tied 1, start pulsed at edge E0:
  - clear at E0+1.
  - enables at E0+3, +25, +47, then +70, +92, +114.
  - weight_iter 0 then 8; pixel_iter 0,1,2 per block.
  - done at E0+136; busy falls at E0+137.
- Same config, blk_ack delayed 5 cycles on each request:
  - blk_req held for 6 cycles with blk_idx=0 then 8.
  - All later events shift by 5 per block; done at E0+146.
- Abort during second pass WAIT:
  - No further enable.
  - IDLE entered exactly when that pass's WAIT expires.
  - done never pulses.
- Abort in BLK_REQ (blk_ack held 0): blk_req drops next cycle, IDLE, busy=0.
- start pulsed while busy:
  - Enable/clear sequence is identical to the no-pulse run.
  - A new start after done restarts with clear and pixel_iter=0.
- rst_n low mid-WAIT: all outputs 0 asynchronously; after release, start gives a full run from clear.
